// File: rtl/pregame_pkg.sv
// Shared state encoding and width helpers for the pre-game sequencer.
// Optional watchdog is enabled by defining PREGAME_TIMEOUT_EN.
package pregame_pkg;

    localparam logic [2:0] ENC_IDLE       = 3'd0;
    localparam logic [2:0] ENC_RESET      = 3'd1;
    localparam logic [2:0] ENC_RESET_WAIT = 3'd2;
    localparam logic [2:0] ENC_WAIT_MODE  = 3'd3;
    localparam logic [2:0] ENC_DELAY      = 3'd4;
    localparam logic [2:0] ENC_REQ        = 3'd5;
    localparam logic [2:0] ENC_WAIT_NAME  = 3'd6;
    localparam logic [2:0] ENC_END        = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE       = ENC_IDLE,
        ST_RESET      = ENC_RESET,
        ST_RESET_WAIT = ENC_RESET_WAIT,
        ST_WAIT_MODE  = ENC_WAIT_MODE,
        ST_DELAY      = ENC_DELAY,
        ST_REQ        = ENC_REQ,
        ST_WAIT_NAME  = ENC_WAIT_NAME,
        ST_END        = ENC_END
    } state_t;

    function automatic int pw_calc(input int max_players);
        return $clog2(max_players + 1);
    endfunction

    function automatic int iw_calc(input int max_players);
        return (max_players > 1) ? $clog2(max_players) : 1;
    endfunction

    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/pregame_cycle_counter.sv
// Clearable saturating up-counter with a registered terminal-count flag
// (done is high while the count equals LIMIT-1).
module pregame_cycle_counter
    import pregame_pkg::*;
#(
    parameter int LIMIT = 16,
    parameter int WIDTH = cnt_width(LIMIT)
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    // Next count: clear dominates, then saturating increment.
    always_comb begin
        count_next_s = count_r;
        if (clear) begin
            count_next_s = '0;
        end else if (enable && (count_r != LAST)) begin
            count_next_s = count_r + WIDTH'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register and terminal flag derived from the next count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= '0;
            done    <= (LAST == '0);
        end else begin
            count_r <= count_next_s;
            done    <= (count_next_s == LAST);
        end
    end

endmodule

// File: rtl/pregame_sequencer.sv
// Pre-game sequencer: model clear, player-count wait, per-player name requests.
// Define PREGAME_TIMEOUT_EN to add the callback watchdog and timeout_err.
module pregame_sequencer
    import pregame_pkg::*;
#(
    parameter int MAX_PLAYERS    = 4,
    parameter int DELAY_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    localparam int PW = pw_calc(MAX_PLAYERS),
    localparam int IW = iw_calc(MAX_PLAYERS)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    input  logic          cbk_from_reset,
    input  logic          cbk_from_view,
    input  logic          cbk_from_end_confirm,
    input  logic [PW-1:0] num_players,
    output logic          clear_req,
    output logic          name_req,
    output logic [IW-1:0] name_idx,
    output logic          name_done,
    output logic          busy
`ifdef PREGAME_TIMEOUT_EN
    , output logic        timeout_err
`endif
);

    if ((MAX_PLAYERS < 1) || (DELAY_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("pregame_sequencer: parameters must be >= 1");
    end

    state_t        state_r;
    state_t        next_state_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] next_idx_s;
    logic [PW-1:0] n_lat_r;
    logic [PW-1:0] next_n_lat_s;
    logic          delay_done_s;
    logic          delay_clear_s;

    assign delay_clear_s = (state_r != ST_DELAY);

    pregame_cycle_counter #(
        .LIMIT (DELAY_CYCLES)
    ) u_delay_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clear  (delay_clear_s),
        .enable (!delay_clear_s),
        .done   (delay_done_s)
    );

`ifdef PREGAME_TIMEOUT_EN
    logic wd_done_s;
    logic wd_clear_s;
    logic timeout_hit_s;

    // Watchdog runs only in the two callback-wait states; any other state holds it at zero.
    assign wd_clear_s = !((state_r == ST_RESET_WAIT) || (state_r == ST_WAIT_NAME));

    pregame_cycle_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wd_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clear  (wd_clear_s),
        .enable (!wd_clear_s),
        .done   (wd_done_s)
    );
`endif

    // Next-state, index and player-count latch logic; abort overrides everything.
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = idx_r;
        next_n_lat_s = n_lat_r;
`ifdef PREGAME_TIMEOUT_EN
        timeout_hit_s = 1'b0;
`endif
        if (abort) begin
            next_state_s = ST_IDLE;
            next_idx_s   = '0;
            next_n_lat_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        next_state_s = ST_RESET;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_RESET: begin
                    next_state_s = ST_RESET_WAIT;
                end
                ST_RESET_WAIT: begin
                    if (cbk_from_reset) begin
                        next_state_s = ST_WAIT_MODE;
                    end
`ifdef PREGAME_TIMEOUT_EN
                    else if (wd_done_s) begin
                        next_state_s  = ST_IDLE;
                        timeout_hit_s = 1'b1;
                    end
`endif
                    else begin
                        next_state_s = ST_RESET_WAIT;
                    end
                end
                ST_WAIT_MODE: begin
                    if (num_players != '0) begin
                        if (num_players > PW'(MAX_PLAYERS)) begin
                            next_n_lat_s = PW'(MAX_PLAYERS);
                        end else begin
                            next_n_lat_s = num_players;
                        end
                        next_idx_s   = '0;
                        next_state_s = ST_DELAY;
                    end else begin
                        next_state_s = ST_WAIT_MODE;
                    end
                end
                ST_DELAY: begin
                    if (delay_done_s) begin
                        next_state_s = ST_REQ;
                    end else begin
                        next_state_s = ST_DELAY;
                    end
                end
                ST_REQ: begin
                    next_state_s = ST_WAIT_NAME;
                end
                ST_WAIT_NAME: begin
                    if (cbk_from_view) begin
                        if (PW'(idx_r) == (n_lat_r - PW'(1))) begin
                            next_state_s = ST_END;
                        end else begin
                            next_idx_s   = idx_r + IW'(1);
                            next_state_s = ST_DELAY;
                        end
                    end
`ifdef PREGAME_TIMEOUT_EN
                    else if (wd_done_s) begin
                        next_state_s  = ST_IDLE;
                        timeout_hit_s = 1'b1;
                    end
`endif
                    else begin
                        next_state_s = ST_WAIT_NAME;
                    end
                end
                ST_END: begin
                    if (cbk_from_end_confirm) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_END;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    next_idx_s   = '0;
                    next_n_lat_s = '0;
                end
            endcase
        end
    end

    // State, index and latched player count registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            n_lat_r <= '0;
        end else begin
            state_r <= next_state_s;
            idx_r   <= next_idx_s;
            n_lat_r <= next_n_lat_s;
        end
    end

    // Outputs are registered from the next state, so each one tracks the current state exactly.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clear_req <= 1'b0;
            name_req  <= 1'b0;
            name_idx  <= '0;
            name_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            clear_req <= (next_state_s == ST_RESET);
            name_req  <= (next_state_s == ST_REQ);
            name_done <= (next_state_s == ST_END);
            busy      <= (next_state_s != ST_IDLE);
            if ((next_state_s == ST_DELAY) || (next_state_s == ST_REQ) ||
                (next_state_s == ST_WAIT_NAME)) begin
                name_idx <= next_idx_s;
            end else begin
                name_idx <= '0;
            end
        end
    end

`ifdef PREGAME_TIMEOUT_EN
    // Watchdog strobe, high for the first IDLE cycle after an expiry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit_s;
        end
    end
`endif

endmodule

// File: tb/tb_pregame_sequencer.sv
// Directed self-checking bench for pregame_sequencer (MAX_PLAYERS=4, DELAY_CYCLES=3).
// Watchdog scenarios run when PREGAME_TIMEOUT_EN is defined.
module tb_pregame_sequencer;

    localparam int MAXP = 4;
    localparam int DLY  = 3;
    localparam int TMO  = 10;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic       abort;
    logic       cbk_from_reset;
    logic       cbk_from_view;
    logic       cbk_from_end_confirm;
    logic [2:0] num_players;
    logic       clear_req;
    logic       name_req;
    logic [1:0] name_idx;
    logic       name_done;
    logic       busy;
`ifdef PREGAME_TIMEOUT_EN
    logic       timeout_err;
`endif

    int tests = 0;
    int fails = 0;
    int clr_cnt = 0;
    int req_cnt = 0;
    int tmo_cnt = 0;

    pregame_sequencer #(
        .MAX_PLAYERS    (MAXP),
        .DELAY_CYCLES   (DLY),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock                (clock),
        .resetn               (resetn),
        .start                (start),
        .abort                (abort),
        .cbk_from_reset       (cbk_from_reset),
        .cbk_from_view        (cbk_from_view),
        .cbk_from_end_confirm (cbk_from_end_confirm),
        .num_players          (num_players),
        .clear_req            (clear_req),
        .name_req             (name_req),
        .name_idx             (name_idx),
        .name_done            (name_done),
        .busy                 (busy)
`ifdef PREGAME_TIMEOUT_EN
        , .timeout_err        (timeout_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are observed on the falling edge.
    task automatic step();
        @(negedge clock);
        if (clear_req === 1'b1) clr_cnt++;
        if (name_req === 1'b1) req_cnt++;
`ifdef PREGAME_TIMEOUT_EN
        if (timeout_err === 1'b1) tmo_cnt++;
`endif
    endtask

    task automatic expect_req(input int exp_idx, input int exp_lat, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while ((name_req !== 1'b1) && (n < 30));
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_idx"}, name_idx, exp_idx);
    endtask

    task automatic run_to_wait_mode(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_clear_req"}, clear_req, 1'b1);
        step();
        cbk_from_reset = 1'b1;
        step();
        cbk_from_reset = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        cbk_from_reset = 1'b0; cbk_from_view = 1'b0; cbk_from_end_confirm = 1'b0;
        num_players = 3'd0;
        step(); step();
        check("rst_outputs", {clear_req, name_req, name_idx, name_done, busy}, 6'd0);
`ifdef PREGAME_TIMEOUT_EN
        check("rst_timeout_err", timeout_err, 1'b0);
`endif
        resetn = 1'b1;
        step();
        check("idle_busy", busy, 1'b0);

        // Three players, callbacks a couple of cycles after each request.
        clr_cnt = 0; req_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_clear_req", clear_req, 1'b1);
        check("t1_busy", busy, 1'b1);
        step();
        check("t1_clear_one_cycle", clear_req, 1'b0);
        cbk_from_reset = 1'b1;
        step();
        cbk_from_reset = 1'b0;
        step();
        check("t1_wait_mode_no_req", {name_req, busy}, 2'b01);
        num_players = 3'd3;
        expect_req(0, DLY + 1, "t1_req0");
        num_players = 3'd1;
        step();
        cbk_from_view = 1'b1;
        expect_req(1, DLY + 1, "t1_req1");
        cbk_from_view = 1'b0;
        step(); step();
        cbk_from_view = 1'b1;
        expect_req(2, DLY + 1, "t1_req2");
        cbk_from_view = 1'b0;
        step();
        cbk_from_view = 1'b1;
        step();
        cbk_from_view = 1'b0;
        check("t1_end", {name_done, busy, name_idx}, 4'b1100);
        step(); step();
        check("t1_end_hold", name_done, 1'b1);
        check("t1_req_count", req_cnt, 3);
        check("t1_clear_count", clr_cnt, 1);
        cbk_from_end_confirm = 1'b1;
        step();
        cbk_from_end_confirm = 1'b0;
        check("t1_back_idle", {busy, name_done}, 2'b00);

        // Player count above MAX_PLAYERS is clamped.
        num_players = 3'd0; req_cnt = 0;
        run_to_wait_mode("t2");
        num_players = 3'd7;
        expect_req(0, DLY + 1, "t2_req0");
        for (int i = 1; i < 4; i++) begin
            step();
            cbk_from_view = 1'b1;
            expect_req(i, DLY + 1, "t2_reqn");
            cbk_from_view = 1'b0;
        end
        step();
        cbk_from_view = 1'b1;
        step();
        cbk_from_view = 1'b0;
        check("t2_end", name_done, 1'b1);
        check("t2_req_count", req_cnt, 4);
        cbk_from_end_confirm = 1'b1;
        step();
        cbk_from_end_confirm = 1'b0;

        // Abort while waiting for the second name.
        num_players = 3'd0;
        run_to_wait_mode("t3");
        num_players = 3'd3;
        expect_req(0, DLY + 1, "t3_req0");
        step();
        cbk_from_view = 1'b1;
        expect_req(1, DLY + 1, "t3_req1");
        cbk_from_view = 1'b0;
        step();
        check("t3_wait_name_idx", name_idx, 2'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t3_abort_idle", {busy, name_idx, name_req}, 4'b0000);
        step(); step(); step();
        check("t3_stays_idle", busy, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t3_restart_clear", clear_req, 1'b1);

        // Asynchronous reset during DELAY.
        step();
        cbk_from_reset = 1'b1;
        step();
        cbk_from_reset = 1'b0;
        num_players = 3'd2;
        step(); step();
        check("t4_in_delay", {busy, name_req}, 2'b10);
        #2 resetn = 1'b0;
        #1 check("t4_async_outputs", {clear_req, name_req, name_idx, name_done, busy}, 6'd0);
        step(); step();
        resetn = 1'b1;
        req_cnt = 0; clr_cnt = 0;
        repeat (10) step();
        check("t4_no_req_after_reset", req_cnt, 0);
        check("t4_idle_after_reset", {busy, clr_cnt[0]}, 2'b00);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4_restart_clear", clear_req, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_abort_from_reset", busy, 1'b0);

`ifdef PREGAME_TIMEOUT_EN
        begin
            int n;
            // cbk_from_reset never arrives: watchdog expiry.
            tmo_cnt = 0;
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            n = 0;
            do begin
                step();
                n++;
            end while ((timeout_err !== 1'b1) && (n < 30));
            check("t5_timeout_latency", n, TMO);
            check("t5_timeout_idle", busy, 1'b0);
            step();
            check("t5_timeout_one_cycle", timeout_err, 1'b0);
            check("t5_timeout_count", tmo_cnt, 1);

            // Callback on the expiry edge wins.
            num_players = 3'd2;
            run_to_wait_mode("t6");
            expect_req(0, DLY + 1, "t6_req0");
            step();
            repeat (TMO - 1) step();
            check("t6_still_waiting", {busy, timeout_err}, 2'b10);
            cbk_from_view = 1'b1;
            step();
            cbk_from_view = 1'b0;
            check("t6_no_timeout", timeout_err, 1'b0);
            check("t6_advanced", {busy, name_idx}, 3'b101);
            expect_req(1, DLY, "t6_req1");
            step();
            cbk_from_view = 1'b1;
            step();
            cbk_from_view = 1'b0;
            check("t6_end", name_done, 1'b1);
            check("t6_timeout_count", tmo_cnt, 1);
            cbk_from_end_confirm = 1'b1;
            step();
            cbk_from_end_confirm = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
